// File: rtl/rf_operand_stage.sv
// rf_operand_stage: register file with write-first bypassed operand capture
// into registered A/B outputs, plus a combinational debug read port.
module rf_operand_stage #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ld,
    input  logic          flush,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] a_q,
    output logic [DW-1:0] b_q,
    output logic          op_valid,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    localparam int N = 1 << AW;
    localparam bit ZR = (ZERO_REG != 0);

    logic [DW-1:0] regs [N];
    logic [DW-1:0] rd1, rd2;
    logic          wr_en;

    // a write to the hardwired zero register is neither stored nor bypassed
    always_comb begin
        wr_en    = we && !(ZR && waddr == '0);
        rd1      = (ZR && raddr1 == '0) ? '0 : (wr_en && waddr == raddr1) ? wdata : regs[raddr1];
        rd2      = (ZR && raddr2 == '0) ? '0 : (wr_en && waddr == raddr2) ? wdata : regs[raddr2];
        dbg_data = (ZR && dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // flush wins over a simultaneous load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_valid <= 1'b0;
        end else if (flush) begin
            a_q      <= '0;
            b_q      <= '0;
            op_valid <= 1'b0;
        end else if (ld) begin
            a_q      <= rd1;
            b_q      <= rd2;
            op_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_operand_stage.sv
// tb_rf_operand_stage: directed scenarios plus a randomized regression
// against an array-based reference model of the register file.
module tb_rf_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        ld = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] a_q, b_q;
    logic        op_valid;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int total = 0;
    int bad = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_a, m_b;
    logic        m_v;

    rf_operand_stage #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ld(ld), .flush(flush), .raddr1(raddr1), .raddr2(raddr2),
        .a_q(a_q), .b_q(b_q), .op_valid(op_valid),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [4:0] addr);
        if (addr == 0) return 32'h0;
        if (we && waddr == addr) return wdata;
        return m_regs[addr];
    endfunction

    function automatic logic [31:0] m_dbg(input logic [4:0] addr);
        return (addr == 0) ? 32'h0 : m_regs[addr];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_a = 0;
        m_b = 0;
        m_v = 0;
    endtask

    // one rising edge: model sees the inputs as they stood before the edge
    task automatic tick();
        logic [31:0] na, nb;
        na = m_read(raddr1);
        nb = m_read(raddr2);
        @(posedge clk);
        if (flush) begin
            m_a = 0; m_b = 0; m_v = 0;
        end else if (ld) begin
            m_a = na; m_b = nb; m_v = 1;
        end
        if (we && waddr != 0) m_regs[waddr] = wdata;
        #1;
    endtask

    task automatic idle();
        we = 0; ld = 0; flush = 0;
    endtask

    task automatic test_reset();
        m_reset();
        #7;
        total++; if (a_q !== 32'h0) begin bad++; $display("FAIL reset_a a_q=%h want=0", a_q); end
        total++; if (b_q !== 32'h0) begin bad++; $display("FAIL reset_b b_q=%h want=0", b_q); end
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_v op_valid=%b want=0", op_valid); end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #0.1;
            total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL reset_dbg[%0d] got=%h want=0", i, dbg_data); end
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        tick();
        waddr = 6; wdata = 32'h12345678;
        tick();
        idle(); raddr1 = 5; raddr2 = 6; ld = 1;
        tick();
        ld = 0;
        total++; if (a_q !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_a a_q=%h want=deadbeef", a_q); end
        total++; if (b_q !== 32'h12345678) begin bad++; $display("FAIL wr_b b_q=%h want=12345678", b_q); end
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL wr_v op_valid=%b want=1", op_valid); end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 9; wdata = 32'hA5A5A5A5; raddr1 = 9; raddr2 = 9; ld = 1; dbg_addr = 9;
        #1;
        total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL byp_dbg_pre got=%h want=0", dbg_data); end
        tick();
        idle();
        total++; if (a_q !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_a a_q=%h want=a5a5a5a5", a_q); end
        total++; if (b_q !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_b b_q=%h want=a5a5a5a5", b_q); end
        total++; if (dbg_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_dbg_post got=%h want=a5a5a5a5", dbg_data); end
    endtask

    task automatic test_zero_reg();
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0; raddr2 = 0; ld = 1; dbg_addr = 0;
        tick();
        idle();
        total++; if (a_q !== 32'h0) begin bad++; $display("FAIL zero_a a_q=%h want=0", a_q); end
        total++; if (b_q !== 32'h0) begin bad++; $display("FAIL zero_b b_q=%h want=0", b_q); end
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL zero_v op_valid=%b want=1", op_valid); end
        total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL zero_dbg got=%h want=0", dbg_data); end
    endtask

    task automatic test_flush();
        raddr1 = 5; raddr2 = 6; ld = 1;
        tick();
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL fl_pre_v op_valid=%b want=1", op_valid); end
        flush = 1; ld = 1;
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            total++; if (a_q !== 32'h0) begin bad++; $display("FAIL fl_a[%0d] a_q=%h want=0", c, a_q); end
            total++; if (b_q !== 32'h0) begin bad++; $display("FAIL fl_b[%0d] b_q=%h want=0", c, b_q); end
            total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL fl_v[%0d] op_valid=%b want=0", c, op_valid); end
            if (c < 3) tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            we = 1; waddr = 5'(10 + c); wdata = $urandom; raddr1 = 5'(10 + c); raddr2 = 5'(9 + c); ld = 1;
            tick();
            total++; if (a_q !== m_a || b_q !== m_b || op_valid !== 1'b1)
                begin bad++; $display("FAIL b2b[%0d] a=%h b=%h v=%b want a=%h b=%h v=1", c, a_q, b_q, op_valid, m_a, m_b); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        raddr1 = 5; raddr2 = 9; ld = 1;
        tick();
        idle();
        #3;
        rst_n = 0;
        dbg_addr = 5;
        #0.5;
        m_reset();
        total++; if (a_q !== 32'h0 || b_q !== 32'h0 || op_valid !== 1'b0)
            begin bad++; $display("FAIL async_rst a=%h b=%h v=%b want 0", a_q, b_q, op_valid); end
        total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL async_rst_dbg got=%h want=0", dbg_data); end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            we = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            ld = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 7) == 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            tick();
            total++; if (a_q !== m_a) begin bad++; $display("FAIL rnd_a[%0d] a_q=%h want=%h", c, a_q, m_a); end
            total++; if (b_q !== m_b) begin bad++; $display("FAIL rnd_b[%0d] b_q=%h want=%h", c, b_q, m_b); end
            total++; if (op_valid !== m_v) begin bad++; $display("FAIL rnd_v[%0d] op_valid=%b want=%b", c, op_valid, m_v); end
            total++; if (dbg_data !== m_dbg(dbg_addr)) begin bad++; $display("FAIL rnd_dbg[%0d] got=%h want=%h", c, dbg_data, m_dbg(dbg_addr)); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_operand_stage.md
Name: rf_operand_stage

Overview:
- Register file plus registered operand stage that sources the rs/rt operands consumed by the ALU source selectors (A and B operand muxes).
- Holds 2^AW general registers with one write port from write-back.
- Latches two read operands into A/B output registers on a load strobe, with same-cycle write-to-read bypass.
- Exposes a combinational debug read port for bench and board inspection.

Parameters:
DW, 32, data width of every register and port
AW, 5, register address width (2^AW registers)
ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write-back enable
waddr  input  AW  write-back register address
wdata  input  DW  write-back data
ld  input  1  load strobe: capture operands this cycle
flush  input  1  discard latched operands
raddr1  input  AW  rs address (operand A)
raddr2  input  AW  rt address (operand B)
a_q  output  DW  latched operand A
b_q  output  DW  latched operand B
op_valid  output  1  a_q/b_q hold a valid captured pair
dbg_addr  input  AW  debug read address
dbg_data  output  DW  debug read data, combinational

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): all registers = 0, a_q = 0, b_q = 0, op_valid = 0. Deassertion takes effect at the next rising edge.
- Write:
  - At the rising edge with we=1, regs[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is dropped.
  - Writes are independent of ld and flush.
- Operand read (bypassed):
  - rd1 = (ZERO_REG && raddr1==0) ? 0 : (we && waddr==raddr1) ? wdata : regs[raddr1].
  - rd2 is the same with raddr2.
  - Bypass gives write-first semantics within a cycle. When waddr=0 and ZERO_REG=1 the bypass is suppressed (result is 0).
- Load, 1-cycle latency:
  - At the edge with ld=1 and flush=0: a_q <= rd1, b_q <= rd2, op_valid <= 1.
  - With ld=0 and flush=0: a_q, b_q and op_valid hold.
- Flush:
  - At the edge with flush=1: a_q <= 0, b_q <= 0, op_valid <= 0.
  - flush has priority over ld; simultaneous ld is ignored.
- Back-to-back ld each cycle: every cycle captures a fresh pair. op_valid stays 1.
- raddr1 == raddr2: both operands receive the identical value, including the bypass case.
- Debug port:
  - dbg_data = (ZERO_REG && dbg_addr==0) ? 0 : regs[dbg_addr].
  - It has no bypass and shows stored state only.
- Reset mid-operation: pending write and load are lost. All state returns to reset values immediately.
- No X propagation: every register has a defined value after reset.

Test Plan:
1. Reset → a_q=0, b_q=0, op_valid=0; dbg_data=0 for all 32 addresses. Reset asserted mid-cycle clears immediately.
2. Write regs[5]=0xDEADBEEF and regs[6]=0x12345678. Next cycle raddr1=5, raddr2=6, ld=1 → one edge later a_q=0xDEADBEEF, b_q=0x12345678, op_valid=1.
3. Same-cycle bypass: we=1, waddr=9, wdata=0xA5A5A5A5, raddr1=9, ld=1 → a_q=0xA5A5A5A5 after that edge; dbg_data(9)=0xA5A5A5A5 only after the edge.
4. Zero register: we=1, waddr=0, wdata=0xFFFFFFFF together with raddr1=0, raddr2=0, ld=1 → a_q=0, b_q=0; dbg_data(0)=0.
5. Flush priority: op_valid=1, then flush=1 and ld=1 together → a_q=0, b_q=0, op_valid=0. Hold with ld=0 for 3 cycles → outputs unchanged.
6. Random regression: 10k cycles of random we/waddr/wdata/ld/flush/raddr against a reference model → a_q, b_q, op_valid and dbg_data match every cycle.
